// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake plus byte-wide data-memory port of the load/store unit
interface load_store_unit_if #(parameter int ADDR_W = 64);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one load/store at a time into byte accesses, little-endian, with legality checks
module load_store_unit #(
  parameter int ADDR_W = 64
) (
  input logic clock,
  input logic reset_n,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [63:0]       wdata;
  logic [63:0]       asm_q;
  logic [2:0]        f3;
  logic [2:0]        cnt;
  logic              wr;
  logic              err;
  logic [2:0]        nm_req;
  logic [2:0]        nm;
  logic              illegal;
  logic              acc;
  logic [63:0]       low;
  logic              sign;
  // nm is N-1, which doubles as the alignment mask and the last byte index
  assign nm_req  = 3'((4'd1 << bus.req_funct3[1:0]) - 4'd1);
  assign nm      = 3'((4'd1 << f3[1:0]) - 4'd1);
  assign illegal = (|(bus.req_addr[2:0] & nm_req)) || (bus.req_write && bus.req_funct3[2]) ||
                   (!bus.req_write && (&bus.req_funct3));
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      base  <= '0;
      wdata <= '0;
      asm_q <= '0;
      f3    <= '0;
      cnt   <= '0;
      wr    <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          base  <= bus.req_addr;
          wdata <= bus.req_wdata;
          f3    <= bus.req_funct3;
          wr    <= bus.req_write;
          cnt   <= '0;
          asm_q <= '0;
          err   <= illegal;
          state <= illegal ? RESP : ACCESS;
        end
        ACCESS: begin
          if (!wr) asm_q[{cnt, 3'b000} +: 8] <= bus.mem_rdata;
          cnt   <= cnt + 3'd1;
          state <= (cnt == nm) ? RESP : ACCESS;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign acc           = state == ACCESS;
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err  = bus.resp_valid && err;
  assign bus.mem_addr  = acc ? base + ADDR_W'(cnt) : '0;
  assign bus.mem_re    = acc && !wr;
  assign bus.mem_we    = acc && wr;
  assign bus.mem_wdata = bus.mem_we ? wdata[{cnt, 3'b000} +: 8] : 8'h00;
  // low covers the 8N assembled bits; everything above is filled from the top assembled bit
  assign low  = 64'hFFFF_FFFF_FFFF_FFFF >> 6'(~{nm, 3'b111});
  assign sign = !f3[2] && asm_q[6'({nm, 3'b111})];
  assign bus.resp_rdata = (bus.resp_valid && !wr && !err) ? (asm_q | (sign ? ~low : 64'd0)) : 64'd0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed load/store vectors against a byte memory model with hand-computed results
module tb_load_store_unit;
  logic       clock = 1'b0;
  logic       reset_n;
  logic       init;
  logic [7:0] mem [0:255];
  int         n_chk = 0;
  int         n_pass = 0;
  load_store_unit_if #(.ADDR_W(64)) bus ();
  load_store_unit #(.ADDR_W(64)) dut (.clock(clock), .reset_n(reset_n), .bus(bus.slave));
  always #5 clock = ~clock;
  assign bus.mem_rdata = bus.mem_re ? mem[bus.mem_addr[7:0]] : 8'h00;
  always @(posedge clock) begin
    if (init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic xact(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                      input logic [63:0] exp_rd, input logic exp_err, input int n);
    int   k;
    logic seen;
    @(negedge clock);
    check("ready_before", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_write = w; bus.req_funct3 = f3; bus.req_addr = a; bus.req_wdata = wd;
    @(negedge clock);
    bus.req_valid = 1'b0; bus.req_addr = '1; bus.req_wdata = '0; bus.req_funct3 = 3'd0;
    k = 1;
    seen = 1'b0;
    while (k <= 12 && !seen) begin
      if (bus.resp_valid) seen = 1'b1;
      else begin
        check("mem_addr", bus.mem_addr, a + 64'(k - 1));
        check("mem_re", 64'(bus.mem_re), 64'(!w));
        check("mem_we", 64'(bus.mem_we), 64'(w));
        if (w) check("mem_wdata", 64'(bus.mem_wdata), 64'(wd[8*(k-1) +: 8]));
        @(negedge clock);
        k++;
      end
    end
    check("resp_seen", 64'(seen), 64'd1);
    check("resp_cycle", 64'(k), exp_err ? 64'd1 : 64'(n + 1));
    check("resp_rdata", bus.resp_rdata, exp_rd);
    check("resp_err", 64'(bus.resp_err), 64'(exp_err));
    check("mem_idle_resp", 64'({bus.mem_re, bus.mem_we}), 64'd0);
    @(negedge clock);
    check("ready_after", 64'(bus.req_ready), 64'd1);
    check("resp_drop", 64'(bus.resp_valid), 64'd0);
  endtask
  initial begin
    reset_n = 1'b0; init = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (2) @(negedge clock);
    init = 1'b0;
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp", 64'({bus.resp_valid, bus.resp_err}), 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    check("rst_mem", 64'({bus.mem_re, bus.mem_we, bus.mem_wdata}), 64'd0);
    check("rst_addr", bus.mem_addr, 64'd0);
    reset_n = 1'b1;
    xact(1'b0, 3'd3, 64'h08, 64'd0, 64'h0F0E0D0C0B0A0908, 1'b0, 8);
    xact(1'b1, 3'd0, 64'h10, 64'h80, 64'd0, 1'b0, 1);
    check("mem10", 64'(mem[8'h10]), 64'h80);
    xact(1'b0, 3'd0, 64'h10, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 1);
    xact(1'b0, 3'd4, 64'h10, 64'd0, 64'h0000000000000080, 1'b0, 1);
    xact(1'b1, 3'd2, 64'h20, 64'hDEADBEEF, 64'd0, 1'b0, 4);
    check("mem20", 64'({mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]}), 64'hDEADBEEF);
    xact(1'b0, 3'd6, 64'h20, 64'd0, 64'h00000000DEADBEEF, 1'b0, 4);
    xact(1'b0, 3'd2, 64'h20, 64'd0, 64'hFFFFFFFFDEADBEEF, 1'b0, 4);
    xact(1'b0, 3'd5, 64'h22, 64'd0, 64'h000000000000DEAD, 1'b0, 2);
    xact(1'b0, 3'd1, 64'h22, 64'd0, 64'hFFFFFFFFFFFFDEAD, 1'b0, 2);
    xact(1'b0, 3'd2, 64'h06, 64'd0, 64'd0, 1'b1, 0);
    xact(1'b1, 3'd4, 64'h00, 64'h55, 64'd0, 1'b1, 0);
    xact(1'b0, 3'd7, 64'h00, 64'd0, 64'd0, 1'b1, 0);
    xact(1'b1, 3'd1, 64'h11, 64'hAAAA, 64'd0, 1'b1, 0);
    check("mem11_untouched", 64'(mem[8'h11]), 64'h11);
    // store interrupted by reset in its third byte cycle
    @(negedge clock);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_funct3 = 3'd3; bus.req_addr = 64'h30;
    bus.req_wdata = 64'h1122334455667788;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pre_we", 64'(bus.mem_we), 64'd1);
    check("rst_pre_addr", bus.mem_addr, 64'h32);
    reset_n = 1'b0;
    #1;
    check("rst_async_we", 64'(bus.mem_we), 64'd0);
    check("rst_async_ready", 64'(bus.req_ready), 64'd1);
    check("rst_async_addr", bus.mem_addr, 64'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("rst_no_resp", 64'({bus.resp_valid, bus.mem_we}), 64'd0);
    end
    check("mem30_31", 64'({mem[8'h31], mem[8'h30]}), 64'h7788);
    check("mem32_37", 64'({mem[8'h37], mem[8'h36], mem[8'h35], mem[8'h34], mem[8'h33], mem[8'h32]}),
          64'h373635343332);
    // back-to-back loads with req_valid held high
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd1; bus.req_addr = 64'h02;
    @(negedge clock);
    check("b2b_busy", 64'(bus.req_ready), 64'd0);
    bus.req_funct3 = 3'd0; bus.req_addr = 64'h05;
    @(negedge clock);
    check("b2b_addr2", bus.mem_addr, 64'h03);
    @(negedge clock);
    check("b2b_resp1", 64'(bus.resp_valid), 64'd1);
    check("b2b_rdata1", bus.resp_rdata, 64'h0302);
    check("b2b_ready_resp", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    check("b2b_ready4", 64'(bus.req_ready), 64'd1);
    check("b2b_noresp4", 64'(bus.resp_valid), 64'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("b2b_addr5", bus.mem_addr, 64'h05);
    check("b2b_re5", 64'(bus.mem_re), 64'd1);
    @(negedge clock);
    check("b2b_resp2", 64'(bus.resp_valid), 64'd1);
    check("b2b_rdata2", bus.resp_rdata, 64'h05);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
